// File: rtl/aclk_lcd_display.sv
// Alarm-clock display driver: picks key buffer, alarm or current time, converts
// each BCD digit to its ASCII glyph and flags a current/alarm time match.
module aclk_lcd_display (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] current_time_ms_hr,
    input  logic [3:0] current_time_ls_hr,
    input  logic [3:0] current_time_ms_min,
    input  logic [3:0] current_time_ls_min,
    input  logic [3:0] alarm_time_ms_hr,
    input  logic [3:0] alarm_time_ls_hr,
    input  logic [3:0] alarm_time_ms_min,
    input  logic [3:0] alarm_time_ls_min,
    input  logic [3:0] key_buffer_ms_hr,
    input  logic [3:0] key_buffer_ls_hr,
    input  logic [3:0] key_buffer_ms_min,
    input  logic [3:0] key_buffer_ls_min,
    input  logic       show_new_time,
    input  logic       show_a,
    output logic       sound_alarm,
    output logic [7:0] display_ms_hr,
    output logic [7:0] display_ls_hr,
    output logic [7:0] display_ms_min,
    output logic [7:0] display_ls_min
);

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_DASH = 8'h2D;

    // Non-decimal nibbles mark an empty or invalid key entry and show as '-'.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return ASCII_ZERO + {4'h0, digit};
        end
        return ASCII_DASH;
    endfunction

    logic [3:0] sel_ms_hr;
    logic [3:0] sel_ls_hr;
    logic [3:0] sel_ms_min;
    logic [3:0] sel_ls_min;
    logic       time_match;

    // Key buffer has priority so a half-typed entry is never hidden by show_a.
    always_comb begin
        sel_ms_hr  = current_time_ms_hr;
        sel_ls_hr  = current_time_ls_hr;
        sel_ms_min = current_time_ms_min;
        sel_ls_min = current_time_ls_min;
        if (show_new_time) begin
            sel_ms_hr  = key_buffer_ms_hr;
            sel_ls_hr  = key_buffer_ls_hr;
            sel_ms_min = key_buffer_ms_min;
            sel_ls_min = key_buffer_ls_min;
        end else if (show_a) begin
            sel_ms_hr  = alarm_time_ms_hr;
            sel_ls_hr  = alarm_time_ls_hr;
            sel_ms_min = alarm_time_ms_min;
            sel_ls_min = alarm_time_ls_min;
        end
    end

    always_comb begin
        time_match = (current_time_ms_hr  == alarm_time_ms_hr)  &&
                     (current_time_ls_hr  == alarm_time_ls_hr)  &&
                     (current_time_ms_min == alarm_time_ms_min) &&
                     (current_time_ls_min == alarm_time_ls_min);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sound_alarm    <= 1'b0;
            display_ms_hr  <= ASCII_ZERO;
            display_ls_hr  <= ASCII_ZERO;
            display_ms_min <= ASCII_ZERO;
            display_ls_min <= ASCII_ZERO;
        end else begin
            sound_alarm    <= time_match;
            display_ms_hr  <= bcd_to_ascii(sel_ms_hr);
            display_ls_hr  <= bcd_to_ascii(sel_ls_hr);
            display_ms_min <= bcd_to_ascii(sel_ms_min);
            display_ls_min <= bcd_to_ascii(sel_ls_min);
        end
    end

endmodule

// File: tb/tb_aclk_lcd_display.sv
// Bench for aclk_lcd_display: directed literal checks plus randomized traffic
// scored against a glyph-table model through an expected-value queue.
module tb_aclk_lcd_display;

    logic       clock;
    logic       reset;
    logic [3:0] current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min;
    logic [3:0] alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
    logic [3:0] key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min;
    logic       show_new_time;
    logic       show_a;
    logic       sound_alarm;
    logic [7:0] display_ms_hr, display_ls_hr, display_ms_min, display_ls_min;

    int n_checks = 0;
    int n_errors = 0;

    // {sound_alarm, ms_hr, ls_hr, ms_min, ls_min}
    logic [32:0] exp_q[$];

    aclk_lcd_display dut (
        .clock               (clock),
        .reset               (reset),
        .current_time_ms_hr  (current_time_ms_hr),
        .current_time_ls_hr  (current_time_ls_hr),
        .current_time_ms_min (current_time_ms_min),
        .current_time_ls_min (current_time_ls_min),
        .alarm_time_ms_hr    (alarm_time_ms_hr),
        .alarm_time_ls_hr    (alarm_time_ls_hr),
        .alarm_time_ms_min   (alarm_time_ms_min),
        .alarm_time_ls_min   (alarm_time_ls_min),
        .key_buffer_ms_hr    (key_buffer_ms_hr),
        .key_buffer_ls_hr    (key_buffer_ls_hr),
        .key_buffer_ms_min   (key_buffer_ms_min),
        .key_buffer_ls_min   (key_buffer_ls_min),
        .show_new_time       (show_new_time),
        .show_a              (show_a),
        .sound_alarm         (sound_alarm),
        .display_ms_hr       (display_ms_hr),
        .display_ls_hr       (display_ls_hr),
        .display_ms_min      (display_ms_min),
        .display_ls_min      (display_ls_min)
    );

    // Clock / reset defaults
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset = 1'b1;
        show_new_time = 1'b0;
        show_a = 1'b0;
        {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min} = 16'h0;
        {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = 16'h0;
        {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min} = 16'h0;
    end

    function automatic logic [32:0] dut_out();
        return {sound_alarm, display_ms_hr, display_ls_hr, display_ms_min, display_ls_min};
    endfunction

    // Reference: each digit looks up its glyph; the match uses raw nibbles.
    function automatic logic [32:0] model(input logic rst, input logic sn, input logic sa,
                                          input logic [15:0] cur, input logic [15:0] alm,
                                          input logic [15:0] key);
        string       glyphs;
        logic [15:0] src;
        logic [31:0] text;
        glyphs = "0123456789------";
        if (rst) return {1'b0, 32'h30303030};
        if (sn)      src = key;
        else if (sa) src = alm;
        else         src = cur;
        for (int i = 0; i < 4; i++) begin
            text[31 - 8*i -: 8] = glyphs[int'(src[15 - 4*i -: 4])];
        end
        return {(cur == alm), text};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got sound=%b digits=%h, expected sound=%b digits=%h",
                     name, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Driver: apply one cycle of inputs at the falling edge and queue the result.
    task automatic drive(input logic rst, input logic sn, input logic sa,
                         input logic [15:0] cur, input logic [15:0] alm, input logic [15:0] key);
        @(negedge clock);
        reset = rst;
        show_new_time = sn;
        show_a = sa;
        {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min} = cur;
        {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = alm;
        {key_buffer_ms_hr, key_buffer_ls_hr, key_buffer_ms_min, key_buffer_ls_min} = key;
        exp_q.push_back(model(rst, sn, sa, cur, alm, key));
    endtask

    // Directed step: drive, then pin the registered result to a hand literal.
    task automatic directed(input string name, input logic rst, input logic sn, input logic sa,
                            input logic [15:0] cur, input logic [15:0] alm, input logic [15:0] key,
                            input logic [32:0] literal);
        drive(rst, sn, sa, cur, alm, key);
        @(posedge clock);
        #2;
        check(name, dut_out(), literal);
    endtask

    // Scoreboard: every cycle with a queued expectation is compared.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                check("scoreboard", dut_out(), exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] cur, alm, key;
        logic        rst, sn, sa;
        int          drain;

        // Reset held two cycles with arbitrary inputs
        directed("reset_1", 1'b1, 1'b1, 1'b1, 16'h9999, 16'h1234, 16'h5F2A, {1'b0, 32'h30303030});
        directed("reset_2", 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1234, 16'hFFFF, {1'b0, 32'h30303030});

        directed("current_mode", 1'b0, 1'b0, 1'b0, 16'h1803, 16'h2487, 16'h0000, {1'b0, 32'h31383033});
        directed("alarm_mode",   1'b0, 1'b0, 1'b1, 16'h1803, 16'h2487, 16'h0000, {1'b0, 32'h32343837});
        directed("key_priority", 1'b0, 1'b1, 1'b1, 16'h1803, 16'h2487, 16'h9C0F, {1'b0, 32'h392D302D});

        directed("match_current", 1'b0, 1'b0, 1'b0, 16'h0630, 16'h0630, 16'h9C0F, {1'b1, 32'h30363330});
        directed("match_alarm",   1'b0, 1'b0, 1'b1, 16'h0630, 16'h0630, 16'h9C0F, {1'b1, 32'h30363330});
        directed("match_key",     1'b0, 1'b1, 1'b0, 16'h0630, 16'h0630, 16'h9C0F, {1'b1, 32'h392D302D});
        directed("match_end",     1'b0, 1'b0, 1'b0, 16'h0631, 16'h0630, 16'h9C0F, {1'b0, 32'h30363331});

        directed("match_again", 1'b0, 1'b1, 1'b0, 16'h0630, 16'h0630, 16'h9C0F, {1'b1, 32'h392D302D});
        directed("mid_reset",   1'b1, 1'b1, 1'b0, 16'h0630, 16'h0630, 16'h9C0F, {1'b0, 32'h30303030});
        directed("after_reset", 1'b0, 1'b1, 1'b0, 16'h0630, 16'h0630, 16'hABCD, {1'b1, 32'h2D2D2D2D});

        // Randomized traffic: mostly valid BCD, frequent forced matches, rare resets
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 4; d++) begin
                cur[15 - 4*d -: 4] = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 9));
                alm[15 - 4*d -: 4] = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 9));
                key[15 - 4*d -: 4] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 2) == 0) alm = cur;
            if ($urandom_range(0, 4) == 0) begin
                alm = cur;
                alm[3:0] = cur[3:0] ^ 4'($urandom_range(1, 15));
            end
            rst = ($urandom_range(0, 29) == 0);
            sn  = 1'($urandom_range(0, 1));
            sa  = 1'($urandom_range(0, 1));
            drive(rst, sn, sa, cur, alm, key);
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(posedge clock);
            drain++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
